// File: rtl/pid_pkg.sv
// Shared constants and FSM state encoding for the PID channel scheduler.
package pid_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned CHN_WIDTH  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } pid_state_e;

endpackage

// File: rtl/ctrl_tick_gen.sv
// Free-running control-period counter; tick_c is high in the last count of each period.
module ctrl_tick_gen #(
  parameter int unsigned PERIOD_CLKS = 27000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_c
);

  localparam int unsigned CNT_W = (PERIOD_CLKS > 2) ? $clog2(PERIOD_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CLKS - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick_c = (cnt == CNT_LAST);

endmodule

// File: rtl/pid_chn_scheduler.sv
// Time-shares one PID core across NUM_CHN motor channels, one sweep per control tick,
// holding per-channel setpoints and latching each result into that channel's duty register.
module pid_chn_scheduler #(
  parameter int unsigned DATA_WIDTH   = pid_pkg::DATA_WIDTH,
  parameter int unsigned NUM_CHN      = 4,
  parameter int unsigned CHN_WIDTH    = pid_pkg::CHN_WIDTH,
  parameter int unsigned PERIOD_CLKS  = 27000,
  parameter int unsigned TIMEOUT_CLKS = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tr_valid_i,
  input  logic [CHN_WIDTH-1:0]          tr_chn_i,
  input  logic [DATA_WIDTH-1:0]         tr_data_i,
  input  logic [NUM_CHN*DATA_WIDTH-1:0] meas_i,
  input  logic                          clr_fault_i,
  output logic                          pid_req_o,
  output logic [CHN_WIDTH-1:0]          pid_chn_o,
  output logic [DATA_WIDTH-1:0]         pid_sp_o,
  output logic [DATA_WIDTH-1:0]         pid_meas_o,
  input  logic                          pid_ack_i,
  input  logic [DATA_WIDTH-1:0]         pid_out_i,
  output logic [NUM_CHN*DATA_WIDTH-1:0] duty_o,
  output logic                          duty_valid_o,
  output logic [CHN_WIDTH-1:0]          duty_chn_o,
  output logic                          busy_o,
  output logic [NUM_CHN-1:0]            fault_o,
  output logic                          overrun_o
);

  import pid_pkg::*;

  localparam int unsigned TO_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [CHN_WIDTH-1:0] LAST_CHN = CHN_WIDTH'(NUM_CHN - 1);

  typedef logic [NUM_CHN-1:0][DATA_WIDTH-1:0] chn_arr_t;

  pid_state_e state, state_nx;
  logic [CHN_WIDTH-1:0]  idx, idx_nx;
  logic [TO_W-1:0]       to_cnt, to_cnt_nx;
  chn_arr_t              sp;
  chn_arr_t              duty_q, duty_nx;
  logic [DATA_WIDTH-1:0] sp_sel, meas_sel;
  logic                  tick;

  logic                  req_nx;
  logic [CHN_WIDTH-1:0]  chn_nx;
  logic [DATA_WIDTH-1:0] sp_nx, meas_nx;
  logic                  dv_nx;
  logic [CHN_WIDTH-1:0]  dv_chn_nx;
  logic                  busy_nx;
  logic [NUM_CHN-1:0]    fault_nx;
  logic                  ovr_nx;

  ctrl_tick_gen #(
    .PERIOD_CLKS (PERIOD_CLKS)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_c (tick)
  );

  // Setpoint bank; writes aimed past the last channel fall through every compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (tr_valid_i) begin
      for (int c = 0; c < NUM_CHN; c++) begin
        if (tr_chn_i == CHN_WIDTH'(c)) begin
          sp[c] <= tr_data_i;
        end
      end
    end
  end

  // Operand select for the channel currently being issued.
  always_comb begin
    sp_sel   = '0;
    meas_sel = '0;
    for (int c = 0; c < NUM_CHN; c++) begin
      if (idx == CHN_WIDTH'(c)) begin
        sp_sel   = sp[c];
        meas_sel = meas_i[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state and next-output logic; a fault/overrun set lands after the clear so set wins.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    to_cnt_nx = to_cnt;
    req_nx    = pid_req_o;
    chn_nx    = pid_chn_o;
    sp_nx     = pid_sp_o;
    meas_nx   = pid_meas_o;
    duty_nx   = duty_q;
    dv_nx     = 1'b0;
    dv_chn_nx = duty_chn_o;
    fault_nx  = fault_o;
    ovr_nx    = overrun_o;

    if (clr_fault_i) begin
      fault_nx = '0;
      ovr_nx   = 1'b0;
    end
    if (tick && (state != IDLE)) begin
      ovr_nx = 1'b1;
    end

    case (state)
      IDLE: begin
        if (tick) begin
          idx_nx   = '0;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        chn_nx    = idx;
        sp_nx     = sp_sel;
        meas_nx   = meas_sel;
        req_nx    = 1'b1;
        to_cnt_nx = '0;
        state_nx  = WAIT;
      end
      WAIT: begin
        if (pid_ack_i) begin
          for (int c = 0; c < NUM_CHN; c++) begin
            if (idx == CHN_WIDTH'(c)) begin
              duty_nx[c] = pid_out_i;
            end
          end
          dv_nx     = 1'b1;
          dv_chn_nx = idx;
          req_nx    = 1'b0;
          state_nx  = GAP;
        end else if (to_cnt == TO_LAST) begin
          for (int c = 0; c < NUM_CHN; c++) begin
            if (idx == CHN_WIDTH'(c)) begin
              fault_nx[c] = 1'b1;
            end
          end
          req_nx   = 1'b0;
          state_nx = GAP;
        end else begin
          to_cnt_nx = to_cnt + TO_W'(1);
        end
      end
      GAP: begin
        if (idx == LAST_CHN) begin
          state_nx = IDLE;
        end else begin
          idx_nx   = idx + CHN_WIDTH'(1);
          state_nx = ISSUE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      to_cnt       <= '0;
      duty_q       <= '0;
      pid_req_o    <= 1'b0;
      pid_chn_o    <= '0;
      pid_sp_o     <= '0;
      pid_meas_o   <= '0;
      duty_valid_o <= 1'b0;
      duty_chn_o   <= '0;
      busy_o       <= 1'b0;
      fault_o      <= '0;
      overrun_o    <= 1'b0;
    end else begin
      state        <= state_nx;
      idx          <= idx_nx;
      to_cnt       <= to_cnt_nx;
      duty_q       <= duty_nx;
      pid_req_o    <= req_nx;
      pid_chn_o    <= chn_nx;
      pid_sp_o     <= sp_nx;
      pid_meas_o   <= meas_nx;
      duty_valid_o <= dv_nx;
      duty_chn_o   <= dv_chn_nx;
      busy_o       <= busy_nx;
      fault_o      <= fault_nx;
      overrun_o    <= ovr_nx;
    end
  end

  assign duty_o = duty_q;

endmodule

// File: tb/tb_pid_chn_scheduler.sv
// Directed bench for pid_chn_scheduler with a delayed-ack PID core model.
module tb_pid_chn_scheduler;

  localparam int unsigned DW  = 16;
  localparam int unsigned NC  = 4;
  localparam int unsigned CW  = 3;
  localparam int unsigned PER = 100;
  localparam int unsigned TO  = 64;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               tr_valid_i = 1'b0;
  logic [CW-1:0]      tr_chn_i = '0;
  logic [DW-1:0]      tr_data_i = '0;
  logic [NC*DW-1:0]   meas_i = '0;
  logic               clr_fault_i = 1'b0;
  logic               pid_req_o;
  logic [CW-1:0]      pid_chn_o;
  logic [DW-1:0]      pid_sp_o;
  logic [DW-1:0]      pid_meas_o;
  logic               pid_ack_i = 1'b0;
  logic [DW-1:0]      pid_out_i = '0;
  logic [NC*DW-1:0]   duty_o;
  logic               duty_valid_o;
  logic [CW-1:0]      duty_chn_o;
  logic               busy_o;
  logic [NC-1:0]      fault_o;
  logic               overrun_o;

  always #5 clk = ~clk;

  pid_chn_scheduler #(
    .DATA_WIDTH   (DW),
    .NUM_CHN      (NC),
    .CHN_WIDTH    (CW),
    .PERIOD_CLKS  (PER),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tr_valid_i   (tr_valid_i),
    .tr_chn_i     (tr_chn_i),
    .tr_data_i    (tr_data_i),
    .meas_i       (meas_i),
    .clr_fault_i  (clr_fault_i),
    .pid_req_o    (pid_req_o),
    .pid_chn_o    (pid_chn_o),
    .pid_sp_o     (pid_sp_o),
    .pid_meas_o   (pid_meas_o),
    .pid_ack_i    (pid_ack_i),
    .pid_out_i    (pid_out_i),
    .duty_o       (duty_o),
    .duty_valid_o (duty_valid_o),
    .duty_chn_o   (duty_chn_o),
    .busy_o       (busy_o),
    .fault_o      (fault_o),
    .overrun_o    (overrun_o)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int ack_delay = 3;
  int skip_chn = -1;
  int cyc = 0;

  always @(posedge clk) cyc++;

  // PID core model: acks ack_delay cycles after req rises with result sp+1.
  int wcnt = 0;
  always @(negedge clk) begin
    pid_ack_i = 1'b0;
    if (pid_req_o) begin
      if (wcnt == ack_delay && int'(pid_chn_o) != skip_chn) begin
        pid_ack_i = 1'b1;
        pid_out_i = pid_sp_o + 16'd1;
      end
      wcnt++;
    end else begin
      wcnt = 0;
    end
  end

  // Event recorder for request edges, duty updates and end of sweep.
  int            rise_cyc[$];
  int            fall_cyc[$];
  int            dv_cyc[$];
  int            busy_fall_cyc[$];
  logic [CW-1:0] rise_chn[$];
  logic [CW-1:0] dv_chn[$];
  logic [DW-1:0] rise_sp[$];
  logic          req_d = 1'b0;
  logic          busy_d = 1'b0;

  always @(negedge clk) begin
    if (pid_req_o && !req_d) begin
      rise_cyc.push_back(cyc);
      rise_chn.push_back(pid_chn_o);
      rise_sp.push_back(pid_sp_o);
    end
    if (!pid_req_o && req_d) fall_cyc.push_back(cyc);
    if (duty_valid_o) begin
      dv_cyc.push_back(cyc);
      dv_chn.push_back(duty_chn_o);
    end
    if (!busy_o && busy_d) busy_fall_cyc.push_back(cyc);
    req_d  = pid_req_o;
    busy_d = busy_o;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_sp(input int chn, input logic [DW-1:0] data);
    @(negedge clk);
    tr_valid_i = 1'b1;
    tr_chn_i   = CW'(chn);
    tr_data_i  = data;
    @(negedge clk);
    tr_valid_i = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_fault_i = 1'b1;
    @(negedge clk);
    clr_fault_i = 1'b0;
    @(negedge clk);
  endtask

  // Waits for busy to rise and fall again, bounded.
  task automatic wait_sweep(input string tag, input int budget);
    int  n = 0;
    bit  seen = 1'b0;
    bit  done = 1'b0;
    while (n < budget && !done) begin
      @(negedge clk);
      if (!seen && busy_o) seen = 1'b1;
      else if (seen && !busy_o) done = 1'b1;
      n++;
    end
    check(tag, 64'(done), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  logic [DW-1:0] exp_sp [4] = '{16'hF1A8, 16'h09A9, 16'h0010, 16'hFFFE};
  int rel_cyc, br, bd, bf, bb, hits, n;

  initial begin
    meas_i = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req",   64'(pid_req_o), 64'd0);
    check("rst_busy",  64'(busy_o), 64'd0);
    check("rst_duty",  64'(duty_o), 64'd0);
    check("rst_fault", 64'(fault_o), 64'd0);
    check("rst_ovr",   64'(overrun_o), 64'd0);
    check("rst_dv",    64'(duty_valid_o), 64'd0);
    rst = 1'b0;
    rel_cyc = cyc;

    // Sweep 1: setpoints, order, latency, duty results
    write_sp(0, 16'hF1A8);
    write_sp(1, 16'h09A9);
    write_sp(2, 16'h0010);
    write_sp(3, 16'hFFFE);
    br = rise_chn.size(); bd = dv_chn.size(); bb = busy_fall_cyc.size();
    wait_sweep("s1_done", 400);
    check("s1_nreq", 64'(rise_chn.size() - br), 64'd4);
    check("s1_ndv",  64'(dv_chn.size() - bd), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("s1_chn%0d", k), 64'(rise_chn[br+k]), 64'(k));
      check($sformatf("s1_sp%0d", k),  64'(rise_sp[br+k]), 64'(exp_sp[k]));
      check($sformatf("s1_dv%0d", k),  64'(dv_chn[bd+k]), 64'(k));
    end
    check("s1_first_req_lat", 64'(rise_cyc[br] - rel_cyc), 64'(PER + 1));
    check("s1_req_spacing",   64'(rise_cyc[br+1] - rise_cyc[br]), 64'd6);
    check("s1_dv_lat",        64'(dv_cyc[bd] - rise_cyc[br]), 64'd4);
    check("s1_busy_fall",     64'(busy_fall_cyc[bb] - rise_cyc[br+3]), 64'd5);
    check("s1_duty",          64'(duty_o), 64'hFFFF_0011_09AA_F1A9);
    check("s1_duty0",         64'(duty_o[15:0]), 64'hF1A9);
    check("s1_fault",         64'(fault_o), 64'd0);
    check("s1_ovr",           64'(overrun_o), 64'd0);

    // Sweep 2: out-of-range write must not disturb setpoints
    write_sp(5, 16'h1234);
    br = rise_chn.size();
    wait_sweep("s2_done", 400);
    check("s2_nreq", 64'(rise_chn.size() - br), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("s2_sp%0d", k), 64'(rise_sp[br+k]), 64'(exp_sp[k]));
    end

    // Sweep 3: channel 2 never acked
    write_sp(2, 16'h0020);
    skip_chn = 2;
    br = rise_chn.size(); bd = dv_chn.size(); bf = fall_cyc.size();
    wait_sweep("s3_done", 400);
    check("s3_nreq", 64'(rise_chn.size() - br), 64'd4);
    check("s3_ndv",  64'(dv_chn.size() - bd), 64'd3);
    check("s3_dv0",  64'(dv_chn[bd]), 64'd0);
    check("s3_dv1",  64'(dv_chn[bd+1]), 64'd1);
    check("s3_dv2",  64'(dv_chn[bd+2]), 64'd3);
    check("s3_timeout_len", 64'(fall_cyc[bf+2] - rise_cyc[br+2]), 64'd64);
    check("s3_fault", 64'(fault_o), 64'b0100);
    check("s3_duty",  64'(duty_o), 64'hFFFF_0011_09AA_F1A9);
    skip_chn = -1;
    pulse_clr();
    check("s3_fault_clr", 64'(fault_o), 64'd0);

    // Sweep 4: slow acks stretch the sweep past the next tick
    ack_delay = 30;
    br = rise_chn.size(); bd = dv_chn.size();
    wait_sweep("s4_done", 500);
    check("s4_ovr",  64'(overrun_o), 64'd1);
    check("s4_ndv",  64'(dv_chn.size() - bd), 64'd4);
    check("s4_duty", 64'(duty_o), 64'hFFFF_0021_09AA_F1A9);
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy_o) hits++;
    end
    check("s4_no_extra_busy", 64'(hits), 64'd0);
    check("s4_no_extra_req",  64'(rise_chn.size() - br), 64'd4);
    pulse_clr();
    check("s4_ovr_clr", 64'(overrun_o), 64'd0);

    // Reset while a request is pending
    n = 0;
    while (n < 300 && !pid_req_o) begin
      @(negedge clk);
      n++;
    end
    check("r_req_seen", 64'(pid_req_o), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("r_req",  64'(pid_req_o), 64'd0);
    check("r_duty", 64'(duty_o), 64'd0);
    check("r_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (n < 300 && !pid_req_o) begin
      @(negedge clk);
      n++;
    end
    check("r_first_req_lat", 64'(n), 64'(PER + 1));
    check("r_chn",  64'(pid_chn_o), 64'd0);
    check("r_sp",   64'(pid_sp_o), 64'd0);
    check("r_meas", 64'(pid_meas_o), 64'h0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pid_chn_scheduler.md
Name: pid_chn_scheduler

Overview:
Sequences one shared PID compute core across NUM_CHN motor channels. Holds per-channel setpoints written by UART_controller through tr_valid/tr_chn/tr_data. On every control-period tick it issues one request per channel, in order 0..NUM_CHN-1, to the PID core. Each result is latched into that channel's duty register, which drives the motor PWM stage.

Parameters:
DATA_WIDTH, 16, setpoint/measurement/duty width, two's-complement signed
NUM_CHN, 4, number of motor channels (2..7)
CHN_WIDTH, 3, channel index width, matches UART_controller tr_chn_o
PERIOD_CLKS, 27000, clk cycles per control tick (1 kHz at 27 MHz)
TIMEOUT_CLKS, 64, maximum cycles to wait for pid_ack_i

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
tr_valid_i  in  1  setpoint write strobe, one cycle, from UART_controller
tr_chn_i  in  CHN_WIDTH  target channel of the write
tr_data_i  in  DATA_WIDTH  new setpoint, already sign-extended
meas_i  in  NUM_CHN*DATA_WIDTH  measured rpm; channel c occupies slice [c*DATA_WIDTH +: DATA_WIDTH]
clr_fault_i  in  1  one-cycle pulse; clears fault_o and overrun_o
pid_req_o  out  1  request to the PID core
pid_chn_o  out  CHN_WIDTH  channel being computed
pid_sp_o  out  DATA_WIDTH  setpoint operand
pid_meas_o  out  DATA_WIDTH  measurement operand
pid_ack_i  in  1  PID result valid, one cycle
pid_out_i  in  DATA_WIDTH  PID result; valid only when pid_ack_i is high
duty_o  out  NUM_CHN*DATA_WIDTH  latched duty per channel, same slicing as meas_i
duty_valid_o  out  1  one-cycle pulse when a duty register updates
duty_chn_o  out  CHN_WIDTH  channel updated, valid with duty_valid_o
busy_o  out  1  high whenever the FSM is not in IDLE
fault_o  out  NUM_CHN  sticky per-channel PID timeout flags
overrun_o  out  1  sticky flag: a tick arrived while busy

Behaviour:
- Reset (async, rst high): all outputs, setpoint registers and duty registers go to 0 immediately. FSM goes to IDLE; tick counter goes to 0. Asserting reset mid-request drops pid_req_o in the same instant.
- Setpoint write: tr_valid_i with tr_chn_i < NUM_CHN loads sp[tr_chn_i] at the next edge. Writes with tr_chn_i >= NUM_CHN are ignored.
- Tick generator: counts 0..PERIOD_CLKS-1 and wraps. The tick is a one-cycle pulse in the count==PERIOD_CLKS-1 cycle. The counter free-runs from reset, independent of the FSM.
- FSM states: IDLE, ISSUE, WAIT, GAP.
  - IDLE: on tick, idx := 0, go to ISSUE.
  - ISSUE (1 cycle): register pid_chn_o=idx, pid_sp_o=sp[idx], pid_meas_o=meas_i slice idx. Set pid_req_o=1 and the timeout counter to 0. Go to WAIT. A setpoint write to idx in this same cycle is not seen until the next period.
  - WAIT: pid_req_o and all operands held stable.
    - On pid_ack_i: duty[idx] := pid_out_i; duty_valid_o=1 and duty_chn_o=idx next cycle; pid_req_o=0 next cycle; go to GAP.
    - If the timeout count reaches TIMEOUT_CLKS-1 with no ack: pid_req_o=0, duty[idx] unchanged, fault_o[idx] := 1, go to GAP.
  - GAP (1 cycle, req low): if idx==NUM_CHN-1 go to IDLE; else idx++ and go to ISSUE.
- Latency:
  - tick in cycle T gives pid_req_o high from T+2 (ISSUE in T+1, registered outputs).
  - ack in cycle A gives the duty update and duty_valid_o in A+1.
  - The next request rises at A+3.
- Overrun: a tick while the FSM is not IDLE sets overrun_o and is dropped, not queued. The current sweep completes normally.
- pid_ack_i seen outside WAIT is ignored.
- clr_fault_i clears fault_o and overrun_o. If a new fault or overrun event occurs in the same cycle, the set wins.
- pid_sp_o, pid_meas_o and pid_chn_o hold their last values when pid_req_o is low.

Decomposition:
- Shared package pid_pkg holds DATA_WIDTH, CHN_WIDTH and the state encodings IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, GAP=2'd3.
- Sub-module ctrl_tick_gen: PERIOD_CLKS counter with tick output, reused by the PWM block.
- Setpoint/duty arrays and the FSM stay in this module.

Test Plan:
1. Setpoint write: write chn0=0xF1A8 (-3672), then chn1=0x09A9 (2473) -> first sweep presents pid_sp_o=0xF1A8 with pid_chn_o=0, then pid_sp_o=0x09A9 with pid_chn_o=1.
2. Full sweep: PID model acks 3 cycles after req with pid_out_i=sp+1 -> four duty_valid_o pulses for chn 0,1,2,3 in order; duty_o chn0 slice=0xF1A9; busy_o falls after chn3's GAP.
3. Timeout: model never acks chn2 -> req drops after 64 WAIT cycles; fault_o=4'b0100; duty chn2 unchanged; chn3 still served. A following clr_fault_i gives fault_o=0.
4. Overrun: PERIOD_CLKS=20, ack delay 10 -> overrun_o=1 on the second tick, no extra sweep started, sweep finishes all 4 channels.
5. Invalid channel: tr_valid_i with tr_chn_i=5, data 0x1234 -> sp[0..3] unchanged in the next sweep.
6. Reset mid-WAIT: assert rst while pid_req_o=1 -> pid_req_o, duty_o and busy_o are 0 immediately. After release, the first request waits for a full PERIOD_CLKS tick.
